wb_sched: RTL and testbench
===========================

Name: wb_sched

Overview:
- Write-back scheduler and busy-bit scoreboard in front of the 32x64 register file.
- Arbitrates two write-back sources, ALU and LSU, onto the register file's single write port (w_reg/w_data/w_en) with round-robin fairness.
- Tracks in-flight destination registers so decode can stall on RAW hazards against the combinational read ports.

Parameters:
- NREG, 32, number of architectural registers; register 0 hard-wired zero.
- AW, 5, register index width (log2 NREG).
- DW, 64, data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- alu_valid  in  1  ALU result pending.
- alu_rd  in  AW  ALU destination register.
- alu_data  in  DW  ALU result.
- alu_ready  out  1  ALU result accepted this cycle (combinational).
- lsu_valid  in  1  LSU result pending.
- lsu_rd  in  AW  LSU destination register.
- lsu_data  in  DW  LSU result.
- lsu_ready  out  1  LSU result accepted this cycle (combinational).
- issue_valid  in  1  decode issues an instruction that writes issue_rd.
- issue_rd  in  AW  destination of the issued instruction.
- chk_rs1  in  AW  source register 1 to check.
- chk_rs2  in  AW  source register 2 to check.
- rs1_busy  out  1  chk_rs1 has a pending write (combinational).
- rs2_busy  out  1  chk_rs2 has a pending write (combinational).
- w_reg  out  AW  register file write index (registered).
- w_data  out  DW  register file write data (registered).
- w_en  out  1  register file write enable (registered).

Behaviour:
- Reset, asynchronous: w_en=0, w_reg=0, w_data=0, busy[NREG-1:0]=0, last=LSU, so the ALU wins the first tie.
- Arbitration is combinational from valids and last:
  - Only one source valid: that source is granted.
  - Both valid: the source other than last is granted.
  - Neither valid: no grant.
- xxx_ready = grant to that source. A transfer occurs on valid && ready. At most one transfer per cycle.
- On a transfer at edge n:
  - w_reg/w_data take the winner's rd/data.
  - w_en = 1 if rd != 0, else 0 (x0 writes are consumed and dropped).
  - last is updated to the winner.
- No transfer at edge n: w_en=0; w_reg/w_data hold their previous values.
- Latency: accept at edge n → w_en high during cycle n..n+1 → register file captures at edge n+1.
- Losing source holds valid/rd/data stable until accepted; the scheduler never drops a valid request.
- Scoreboard:
  - issue_valid with issue_rd != 0 sets busy[issue_rd] at the edge.
  - w_en=1 clears busy[w_reg] at the edge, i.e. on the same edge the register file writes. A cleared register is therefore readable with correct data the next cycle.
  - Same-edge set and clear on the same index: set wins, because the newer producer is pending.
  - busy[0] is never set and always reads 0.
- Hazard outputs:
  - rsN_busy = busy[chk_rsN] && chk_rsN != 0.
  - No bypass: the cycle in which w_en is high still reports busy.
- Reset asserted mid-operation: all pending busy bits and any registered write are discarded immediately. Sources must re-present after reset.
- Starvation bound: under continuous contention each source is granted at least every 2 cycles.

Test Plan:
- Reset, then ALU alone: alu_valid=1, rd=5, data=0xA5 at cycle 1 → alu_ready=1 cycle 1; cycle 2 w_en=1, w_reg=5, w_data=0xA5; cycle 3 w_en=0.
- Both valid for 4 cycles, ALU rd=1..4, LSU rd=9..12 → grants ALU,LSU,ALU,LSU; w_reg sequence 1,9,2,10; each source's data held until its ready.
- Write to x0: lsu_valid=1, rd=0, data=0xFF → lsu_ready=1, next cycle w_en=0; busy[0] never asserted even with issue_rd=0.
- Scoreboard RAW: issue rd=7 → chk_rs1=7 gives rs1_busy=1. ALU returns rd=7 → rs1_busy still 1 in the w_en cycle, 0 the cycle after.
- Set/clear collision: w_en=1, w_reg=3 and issue_valid=1, issue_rd=3 on the same cycle → busy[3]=1 afterwards.
- Async reset mid-stream: busy[2], busy[8] set and w_en=1; assert rst between edges → w_en, rs*_busy drop to 0 immediately; after release ALU wins the first tie.

Source files
------------

// File: rtl/wb_sched.sv
// Write-back scheduler and busy-bit scoreboard for the 32x64 register file.
//
// Purpose:
//   Round-robin arbiter that merges ALU and LSU write-back results onto the
//   register file's single write port, plus a per-register busy scoreboard
//   that decode uses to stall on RAW hazards.
//
// Ports:
//   clk, rst                        clock, async active-high reset
//   alu_valid/alu_rd/alu_data       ALU write-back request
//   alu_ready                       ALU request accepted this cycle (comb)
//   lsu_valid/lsu_rd/lsu_data       LSU write-back request
//   lsu_ready                       LSU request accepted this cycle (comb)
//   issue_valid/issue_rd            decode marks issue_rd as pending
//   chk_rs1/chk_rs2                 source registers to check
//   rs1_busy/rs2_busy               source has a pending write (comb)
//   w_reg/w_data/w_en               registered register file write port
module wb_sched #(
   parameter int NREG = 32,
   parameter int AW   = 5,
   parameter int DW   = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          alu_valid,
   input  logic [AW-1:0] alu_rd,
   input  logic [DW-1:0] alu_data,
   output logic          alu_ready,
   input  logic          lsu_valid,
   input  logic [AW-1:0] lsu_rd,
   input  logic [DW-1:0] lsu_data,
   output logic          lsu_ready,
   input  logic          issue_valid,
   input  logic [AW-1:0] issue_rd,
   input  logic [AW-1:0] chk_rs1,
   input  logic [AW-1:0] chk_rs2,
   output logic          rs1_busy,
   output logic          rs2_busy,
   output logic [AW-1:0] w_reg,
   output logic [DW-1:0] w_data,
   output logic          w_en
);

   localparam logic SRC_ALU = 1'b0;
   localparam logic SRC_LSU = 1'b1;

   logic            last;
   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_next;
   logic [NREG-1:0] set_mask;
   logic [NREG-1:0] clr_mask;
   logic            xfer;
   logic [AW-1:0]   win_rd;
   logic [DW-1:0]   win_data;

   // On a tie the source that did not win last time is granted.
   always_comb begin
      alu_ready = alu_valid && (!lsu_valid || last == SRC_LSU);
      lsu_ready = lsu_valid && (!alu_valid || last == SRC_ALU);
      xfer      = alu_ready || lsu_ready;
      win_rd    = alu_ready ? alu_rd   : lsu_rd;
      win_data  = alu_ready ? alu_data : lsu_data;
   end

   // Set is OR'd in after the clear so a newer producer of the same register
   // keeps it busy. x0 is never marked.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (issue_valid && issue_rd != '0)
         set_mask[issue_rd] = 1'b1;
      if (w_en)
         clr_mask[w_reg] = 1'b1;
      busy_next = (busy & ~clr_mask) | set_mask;
   end

   // No bypass: the register stays busy during its own w_en cycle.
   always_comb begin
      rs1_busy = busy[chk_rs1] && chk_rs1 != '0;
      rs2_busy = busy[chk_rs2] && chk_rs2 != '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last   <= SRC_LSU;
         busy   <= '0;
         w_en   <= 1'b0;
         w_reg  <= '0;
         w_data <= '0;
      end else begin
         busy <= busy_next;
         // x0 results are consumed but never written.
         w_en <= xfer && win_rd != '0;
         if (xfer) begin
            w_reg  <= win_rd;
            w_data <= win_data;
            last   <= lsu_ready ? SRC_LSU : SRC_ALU;
         end
      end
   end

endmodule

// File: tb/tb_wb_sched.sv
// Bench for wb_sched: directed stimulus, expected writes queued in a
// scoreboard and popped by a monitor whenever w_en is seen high.
module tb_wb_sched;

   logic          clk;
   logic          rst;
   logic          alu_valid;
   logic [4:0]    alu_rd;
   logic [63:0]   alu_data;
   logic          alu_ready;
   logic          lsu_valid;
   logic [4:0]    lsu_rd;
   logic [63:0]   lsu_data;
   logic          lsu_ready;
   logic          issue_valid;
   logic [4:0]    issue_rd;
   logic [4:0]    chk_rs1;
   logic [4:0]    chk_rs2;
   logic          rs1_busy;
   logic          rs2_busy;
   logic [4:0]    w_reg;
   logic [63:0]   w_data;
   logic          w_en;

   typedef struct packed {
      logic [4:0]  rd;
      logic [63:0] data;
   } wr_t;

   wr_t sb_q[$];
   wr_t mon_e;
   int  errors = 0;
   int  checks = 0;

   wb_sched #(.NREG(32), .AW(5), .DW(64)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .w_reg(w_reg), .w_data(w_data), .w_en(w_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [4:0] rd, input logic [63:0] data);
      wr_t e;
      e.rd   = rd;
      e.data = data;
      sb_q.push_back(e);
   endtask

   // Monitor: every observed register file write must match the oldest
   // expected write.
   always @(negedge clk) begin
      if (w_en) begin
         if (sb_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_write: got w_reg=%0d w_data=%h expected no write at %0t",
                     w_reg, w_data, $time);
         end else begin
            mon_e = sb_q.pop_front();
            chk("sb_w_reg", 64'(w_reg), 64'(mon_e.rd));
            chk("sb_w_data", w_data, mon_e.data);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ai;
      int li;
      logic exp_alu;

      rst = 1'b1;
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
      issue_valid = 0; issue_rd = 0; chk_rs1 = 5'd5; chk_rs2 = 5'd9;
      #1;
      chk("rst_w_en", 64'(w_en), 64'd0);
      chk("rst_w_reg", 64'(w_reg), 64'd0);
      chk("rst_w_data", w_data, 64'd0);
      chk("rst_rs1_busy", 64'(rs1_busy), 64'd0);
      chk("rst_rs2_busy", 64'(rs2_busy), 64'd0);
      tick();
      tick();
      rst = 1'b0;

      // ALU alone: rd 5, data A5
      tick();
      alu_valid = 1; alu_rd = 5'd5; alu_data = 64'hA5;
      #1;
      chk("alu_only_ready", 64'(alu_ready), 64'd1);
      chk("alu_only_lsu_ready", 64'(lsu_ready), 64'd0);
      push(5'd5, 64'hA5);
      tick();
      alu_valid = 0;
      tick();
      chk("alu_only_w_en_drop", 64'(w_en), 64'd0);

      // LSU write to x0 with simultaneous issue of x0
      lsu_valid = 1; lsu_rd = 5'd0; lsu_data = 64'hFF;
      issue_valid = 1; issue_rd = 5'd0; chk_rs1 = 5'd0; chk_rs2 = 5'd0;
      #1;
      chk("x0_lsu_ready", 64'(lsu_ready), 64'd1);
      chk("x0_alu_ready", 64'(alu_ready), 64'd0);
      tick();
      lsu_valid = 0; issue_valid = 0;
      #1;
      chk("x0_w_en", 64'(w_en), 64'd0);
      chk("x0_w_reg", 64'(w_reg), 64'd0);
      chk("x0_w_data", w_data, 64'hFF);
      chk("x0_rs1_busy", 64'(rs1_busy), 64'd0);

      // Contention: last=LSU now, so ALU,LSU alternate starting with ALU
      tick();
      ai = 0; li = 0;
      alu_valid = 1; alu_rd = 5'd1; alu_data = 64'h100;
      lsu_valid = 1; lsu_rd = 5'd9; lsu_data = 64'h200;
      for (int k = 0; k < 8; k++) begin
         exp_alu = (k % 2 == 0);
         #1;
         chk("rr_alu_ready", 64'(alu_ready), 64'(exp_alu));
         chk("rr_lsu_ready", 64'(lsu_ready), 64'(!exp_alu));
         if (exp_alu) push(alu_rd, alu_data);
         else         push(lsu_rd, lsu_data);
         tick();
         if (exp_alu) begin
            ai++;
            if (ai == 4) alu_valid = 0;
            else begin alu_rd = 5'(1 + ai); alu_data = 64'h100 + 64'(ai); end
         end else begin
            li++;
            if (li == 4) lsu_valid = 0;
            else begin lsu_rd = 5'(9 + li); lsu_data = 64'h200 + 64'(li); end
         end
      end

      // RAW scoreboard on x7
      tick();
      chk_rs1 = 5'd7; chk_rs2 = 5'd0;
      #1;
      chk("raw_idle", 64'(rs1_busy), 64'd0);
      issue_valid = 1; issue_rd = 5'd7;
      tick();
      issue_valid = 0;
      chk("raw_set", 64'(rs1_busy), 64'd1);
      chk("raw_rs2_x0", 64'(rs2_busy), 64'd0);
      alu_valid = 1; alu_rd = 5'd7; alu_data = 64'h77;
      push(5'd7, 64'h77);
      tick();
      alu_valid = 0;
      chk("raw_w_en_cycle", 64'(rs1_busy), 64'd1);
      chk("raw_w_en_high", 64'(w_en), 64'd1);
      tick();
      chk("raw_cleared", 64'(rs1_busy), 64'd0);

      // Same-edge set and clear on x3
      chk_rs1 = 5'd3;
      issue_valid = 1; issue_rd = 5'd3;
      tick();
      issue_valid = 0;
      alu_valid = 1; alu_rd = 5'd3; alu_data = 64'h33;
      push(5'd3, 64'h33);
      #1;
      chk("coll_pre", 64'(rs1_busy), 64'd1);
      tick();
      alu_valid = 0;
      issue_valid = 1; issue_rd = 5'd3;
      tick();
      issue_valid = 0;
      chk("coll_set_wins", 64'(rs1_busy), 64'd1);
      tick();
      chk("coll_hold", 64'(rs1_busy), 64'd1);
      alu_valid = 1; alu_rd = 5'd3; alu_data = 64'h34;
      push(5'd3, 64'h34);
      tick();
      alu_valid = 0;
      tick();
      chk("coll_final_clear", 64'(rs1_busy), 64'd0);

      // Async reset mid-stream
      chk_rs1 = 5'd2; chk_rs2 = 5'd8;
      issue_valid = 1; issue_rd = 5'd2;
      tick();
      issue_rd = 5'd8;
      tick();
      issue_valid = 0;
      chk("mid_busy2", 64'(rs1_busy), 64'd1);
      chk("mid_busy8", 64'(rs2_busy), 64'd1);
      alu_valid = 1; alu_rd = 5'd4; alu_data = 64'h44;
      tick();
      alu_valid = 0;
      chk("mid_w_en_pre", 64'(w_en), 64'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_w_en", 64'(w_en), 64'd0);
      chk("mid_rst_w_reg", 64'(w_reg), 64'd0);
      chk("mid_rst_w_data", w_data, 64'd0);
      chk("mid_rst_rs1", 64'(rs1_busy), 64'd0);
      chk("mid_rst_rs2", 64'(rs2_busy), 64'd0);
      tick();
      tick();
      rst = 1'b0;
      alu_valid = 1; alu_rd = 5'd13; alu_data = 64'hDD;
      lsu_valid = 1; lsu_rd = 5'd14; lsu_data = 64'hEE;
      #1;
      chk("post_rst_alu_first", 64'(alu_ready), 64'd1);
      chk("post_rst_lsu_wait", 64'(lsu_ready), 64'd0);
      push(5'd13, 64'hDD);
      tick();
      alu_valid = 0;
      chk("post_rst_lsu_next", 64'(lsu_ready), 64'd1);
      push(5'd14, 64'hEE);
      tick();
      lsu_valid = 0;
      tick();
      tick();
      chk("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
